// File: rtl/rd_frame_buf.sv
// rd_frame_buf: 1-clock true dual-port read-first line buffer between DDR read data and the output path.
// Port A wins a same-address write collision; reset clears only the read registers.
module rd_frame_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  b_wr_en,
  output logic [DATA_WIDTH-1:0] b_rd_data
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic                  w_b_wr;
  assign w_b_wr = b_wr_en && !(a_wr_en && a_addr == b_addr);
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (a_wr_en) r_mem[a_addr] <= a_wr_data;
      if (w_b_wr) r_mem[b_addr] <= b_wr_data;
    end
  end
  // Reads sample the array before this edge's writes land, giving read-first behaviour.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_rd_data <= '0;
      b_rd_data <= '0;
    end else begin
      a_rd_data <= r_mem[a_addr];
      b_rd_data <= r_mem[b_addr];
    end
  end
endmodule

// File: tb/tb_rd_frame_buf.sv
// tb_rd_frame_buf: reference model plus directed literal checks for rd_frame_buf.
module tb_rd_frame_buf;
  logic         clk = 0;
  logic         rstn = 0;
  logic [9:0]   a_addr = 0, b_addr = 0;
  logic [127:0] a_wr_data = 0, b_wr_data = 0;
  logic         a_wr_en = 0, b_wr_en = 0;
  logic [127:0] a_rd_data, b_rd_data;
  int tests = 0, fails = 0;

  rd_frame_buf dut (
    .clk(clk), .rstn(rstn),
    .a_addr(a_addr), .a_wr_data(a_wr_data), .a_wr_en(a_wr_en), .a_rd_data(a_rd_data),
    .b_addr(b_addr), .b_wr_data(b_wr_data), .b_wr_en(b_wr_en), .b_rd_data(b_rd_data)
  );

  always #5 clk = ~clk;

  logic [127:0] m [int];
  logic [127:0] ea = 0, eb = 0;
  bit           ea_v = 1, eb_v = 1;

  always @(negedge rstn) begin
    ea = 0; eb = 0; ea_v = 1; eb_v = 1;
  end

  always @(posedge clk) begin
    if (rstn) begin
      ea_v = m.exists(int'(a_addr));
      eb_v = m.exists(int'(b_addr));
      ea = ea_v ? m[int'(a_addr)] : 0;
      eb = eb_v ? m[int'(b_addr)] : 0;
      if (b_wr_en) m[int'(b_addr)] = b_wr_data;
      if (a_wr_en) m[int'(a_addr)] = a_wr_data;
    end
  end

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ea_v) chk("model_a", a_rd_data, ea);
    if (eb_v) chk("model_b", b_rd_data, eb);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick; tick;
    rstn = 1;
    a_addr = 5; a_wr_data = 128'h5A5A; a_wr_en = 1;
    tick;
    a_wr_en = 0; b_addr = 5;
    tick;
    chk("pre_reset_b", b_rd_data, 128'h5A5A);
    rstn = 0;
    #1;
    chk("async_rst_a", a_rd_data, 0);
    chk("async_rst_b", b_rd_data, 0);
    tick;
    chk("held_rst_b", b_rd_data, 0);
    rstn = 1;
    tick;
    chk("post_rst_a5", a_rd_data, 128'h5A5A);

    a_addr = 0; a_wr_data = 128'h0123456789ABCDEF0123456789ABCDEF; a_wr_en = 1;
    tick;
    a_addr = 1023; a_wr_data = '1;
    tick;
    a_wr_en = 0; b_addr = 0;
    tick;
    chk("basic_b0", b_rd_data, 128'h0123456789ABCDEF0123456789ABCDEF);
    b_addr = 1023;
    tick;
    chk("basic_b1023", b_rd_data, '1);

    a_wr_en = 1;
    for (int i = 0; i < 1024; i++) begin
      a_addr = 10'(i); a_wr_data = 128'(i * 17);
      tick;
    end
    a_wr_en = 0;
    for (int i = 0; i <= 1024; i++) begin
      b_addr = 10'(i % 1024);
      tick;
      if (i == 5) chk("stream_5", b_rd_data, 128'h55);
      if (i == 1023) chk("stream_1023", b_rd_data, 128'h43EF);
      if (i == 1024) chk("stream_wrap0", b_rd_data, 0);
    end

    a_addr = 7; a_wr_data = 128'hAA; a_wr_en = 1;
    tick;
    a_wr_data = 128'hBB; b_addr = 7;
    tick;
    chk("rf_old_a", a_rd_data, 128'hAA);
    chk("rf_old_b", b_rd_data, 128'hAA);
    a_wr_en = 0;
    tick;
    chk("rf_new_a", a_rd_data, 128'hBB);
    chk("rf_new_b", b_rd_data, 128'hBB);

    a_addr = 9; b_addr = 9; a_wr_data = 128'h11; b_wr_data = 128'h22; a_wr_en = 1; b_wr_en = 1;
    tick;
    a_wr_en = 0; b_wr_en = 0;
    tick;
    chk("coll_a", a_rd_data, 128'h11);
    chk("coll_b", b_rd_data, 128'h11);

    a_addr = 3; a_wr_data = 128'h33; a_wr_en = 1;
    tick;
    a_wr_en = 0;
    tick;
    rstn = 0;
    a_wr_data = 128'h55; a_wr_en = 1; b_addr = 3; b_wr_data = 128'h66; b_wr_en = 1;
    tick;
    a_wr_en = 0; b_wr_en = 0;
    rstn = 1;
    tick;
    chk("rst_wr_blk_a", a_rd_data, 128'h33);
    chk("rst_wr_blk_b", b_rd_data, 128'h33);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rd_frame_buf.md
# rd_frame_buf

Single-clock true dual-port RAM used as the 128-bit line buffer between DDR read data and the pixel/PCIe output path. Port A is written by the DDR read-return stream; port B is read by the consumer. Both ports can read and write. The buffer holds 1024 words of 128 bits, addressed as a ring by the surrounding logic.

## Interface
- DATA_WIDTH, 128: word width in bits.
- ADDR_WIDTH, 10: address width; depth = 2^ADDR_WIDTH = 1024 words.
- clk  in  1  the single clock for both ports, rising edge.
- rstn  in  1  reset, asynchronous and active-low; clears the output registers only.
- a_addr  in  ADDR_WIDTH  port A word address.
- a_wr_data  in  DATA_WIDTH  port A write data.
- a_wr_en  in  1  port A write enable.
- a_rd_data  out  DATA_WIDTH  port A registered read data.
- b_addr  in  ADDR_WIDTH  port B word address.
- b_wr_data  in  DATA_WIDTH  port B write data.
- b_wr_en  in  1  port B write enable.
- b_rd_data  out  DATA_WIDTH  port B registered read data.

## Operation
- Memory is an array of 2^ADDR_WIDTH words of DATA_WIDTH bits. There is no init value; contents are undefined until written.
- Each port reads on every clock, with no read enable. The rd_data register captures mem[addr] as it was before this edge's writes (read-first).
- A write happens at the rising edge when wr_en=1 and rstn=1: mem[addr] <= wr_data.
- Same-port read-during-write: rd_data returns the old contents. The new value is visible on the next read of that address.
- Cross-port read-during-write (A writes X while B reads X, or the reverse): the reading port returns the old contents.
- Write collision (both ports write the same address in the same cycle): port A's data is stored and port B's write is dropped.
- Different addresses on the two ports are fully independent.
- Reset (rstn=0):
  - Asynchronously forces a_rd_data and b_rd_data to 0.
  - Holds both output registers at 0 while low.
  - Blocks all writes.
  - Leaves memory contents unchanged.
- Addresses cover the full range 0..2^ADDR_WIDTH-1. Wrap-around is the user's job; address 1023 followed by 0 needs no special case.

## Timing
- Read latency is 1 cycle. Address applied before edge N gives data on rd_data after edge N, valid through edge N+1.
- Write latency is 1 cycle. Data written at edge N can be read with the address applied after edge N, and appears after edge N+1.
- Reset assertion affects the outputs immediately (asynchronous), with no clock needed.
- Reset deassertion is synchronous in effect. The first read/write happens at the first rising edge with rstn=1, and rd_data gets valid contents after that edge.
- Reset value of every output is 0.
- There is no handshake and no stall; both ports accept a new operation every cycle.

## Test plan
- Reset: drive rstn=0 with nonzero memory contents, then check a_rd_data = b_rd_data = 0 with no clock edge. Release reset, read address 5, and check the previous contents return.
- Basic A-write/B-read:
  - Write 0x0123...CDEF (128-bit) to addr 0 and all-ones to addr 1023 via A.
  - Read both via B and check each value appears one cycle after its address.
- Streaming: A writes word i = i*0x11 to addresses 0..1023, one per cycle. B then reads 0..1023 back-to-back and must match every word, including the 1023 to 0 wrap.
- Read-first:
  - mem[7]=0xAA. In one cycle, A writes 0xBB to 7 while both A and B read 7; both outputs show 0xAA.
  - On the next cycle both outputs show 0xBB.
- Collision: in one cycle, A writes 0x11 and B writes 0x22 to addr 9. A later read of 9 returns 0x11.
- Write during reset: hold rstn=0, pulse a_wr_en with addr 3 = 0x55, release reset, read addr 3. The pre-reset value returns unchanged.
